gate_seq: RTL
=============

GATE_SEQ -- requirements
Module: gate_seq

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 50000, number of consecutive stable cycles needed to accept a button level.
REQ-002 SHALL have parameter TICK_DIV, default 25000000, number of clk cycles per AUTO operand step.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have ports btn0, btn1, inputs, 1 each, raw asynchronous operand buttons.
REQ-006 SHALL have port btn2, input, 1, raw asynchronous mode button.
REQ-007 SHALL have ports led0..led6, outputs, 1 each, registered gate results: NOT a, AND, OR, NAND, NOR, XOR, XNOR of operands (a,b).
REQ-008 SHALL have port led7, output, 1, mode indicator: 1 in AUTO or PAUSED, 0 in MANUAL.

Function
REQ-009 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-010 SHALL debounce each synchronized button: the debounced level changes only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any glitch clears that button's counter.
REQ-011 SHALL produce a one-cycle press pulse on each 0->1 transition of a debounced level.
REQ-012 SHALL implement states MANUAL, AUTO and PAUSED (PAUSED exists only per REQ-024).
REQ-013 SHALL toggle between MANUAL and AUTO on a btn2 press pulse; from PAUSED, a btn2 press SHALL go to MANUAL.
REQ-014 SHALL load operands (a,b) from debounced (btn0,btn1) every cycle in MANUAL.
REQ-015 SHALL, in AUTO, run a tick counter 0..TICK_DIV-1 and advance (a,b) 00->01->10->11->00 (b is the LSB) in the cycle the counter wraps.
REQ-016 SHALL reload operands 00 and clear the tick counter on entry to AUTO from MANUAL.
REQ-017 SHALL register led0..led6 from the operand register, with one cycle of latency from an operand change to the LED change.
REQ-018 SHALL update led7 in the same cycle as the state register.
REQ-019 SHALL, when a btn2 press and a tick wrap occur in the same cycle, apply the mode change and not advance the operands.
REQ-020 SHALL ignore btn0/btn1 press pulses in AUTO, except as given in REQ-024.

Reset
REQ-021 SHALL, when rst=1 at a clk edge, set state MANUAL, operands 00, tick and debounce counters 0, debounced levels 0, synchronizers 0, led0..led7 0.
REQ-022 SHALL, when rst is asserted mid-step or mid-debounce, abandon the partial count; the first LED values after reset appear 2 cycles after rst deasserts (led0=1, led4=1, led6=1, all others 0 with buttons released).
REQ-023 SHALL generate no press pulse from reset release alone.

Configuration
REQ-024 SHALL, with macro GATE_SEQ_FREEZE_EN defined, treat a btn0 press pulse as AUTO->PAUSED and PAUSED->AUTO; in PAUSED, operands and the tick counter hold and led7=1; resuming continues from the held count.
REQ-025 SHALL, without GATE_SEQ_FREEZE_EN, contain no PAUSED state and ignore btn0 in AUTO.

Verification (DEB_CYCLES=4, TICK_DIV=8)
REQ-026 SHALL cover: rst for 2 cycles, buttons 0 -> led[7:0]=0 during reset; led0, led4 and led6 =1 two cycles after release.
REQ-027 SHALL cover: MANUAL, btn0=1 held 2 cycles then 0 -> no operand change; btn0 held 10 cycles -> a=1 after sync + 4 cycles; led2=1 and led5=1 one cycle later.
REQ-028 SHALL cover: btn2 press -> led7=1, operands 00, then steps 01,10,11,00 every 8 cycles; led1=1 only in step 11.
REQ-029 SHALL cover: btn2 press pulse coincident with a tick wrap in AUTO -> MANUAL, operands not advanced.
REQ-030 SHALL cover, with GATE_SEQ_FREEZE_EN: btn0 press at operands 10 -> held at 10 for 40 cycles; second press -> 11 after the remaining tick count; without the macro, operands keep stepping.
REQ-031 SHALL cover: rst asserted at tick count 5 in AUTO -> MANUAL, led7=0, tick counter 0.

Source files
------------

// File: rtl/gate_seq_if.sv
// gate_seq_if -- button and LED bundle for gate_seq.
//   btn0, btn1 : raw operand buttons (a, b), asynchronous
//   btn2       : raw mode button, asynchronous
//   led0..led6 : NOT a, AND, OR, NAND, NOR, XOR, XNOR of (a, b)
//   led7       : mode indicator (1 = AUTO or PAUSED)
// master drives the buttons (board / testbench), slave is the gate_seq core.
interface gate_seq_if;
  logic btn0;
  logic btn1;
  logic btn2;
  logic led0;
  logic led1;
  logic led2;
  logic led3;
  logic led4;
  logic led5;
  logic led6;
  logic led7;

  modport master (
    output btn0, btn1, btn2,
    input  led0, led1, led2, led3, led4, led5, led6, led7
  );

  modport slave (
    input  btn0, btn1, btn2,
    output led0, led1, led2, led3, led4, led5, led6, led7
  );
endinterface

// File: rtl/gate_seq.sv
// gate_seq -- logic-gate demonstrator with manual and auto-stepping operands.
// Ports:
//   clk : single clock, all state changes on its rising edge
//   rst : synchronous, active-high reset
//   io  : gate_seq_if.slave (buttons in, LEDs out)
// Parameters:
//   DEB_CYCLES : consecutive stable cycles before a button level is accepted
//   TICK_DIV   : clk cycles per operand step in AUTO
// Build option:
//   GATE_SEQ_FREEZE_EN : when defined, btn0 pauses/resumes AUTO stepping
//
// state   | meaning
// --------+--------------------------------------------------------------
// MANUAL  | operands follow debounced btn0/btn1 every cycle, led7 = 0
// AUTO    | operands step 00->01->10->11 once per TICK_DIV cycles, led7 = 1
// PAUSED  | (freeze builds only) operands and tick count held, led7 = 1
module gate_seq #(
  parameter int DEB_CYCLES = 50000,
  parameter int TICK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  gate_seq_if.slave  io
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
`ifdef GATE_SEQ_FREEZE_EN
    ST_PAUSED = 2'd2,
`endif
    ST_MANUAL = 2'd0,
    ST_AUTO   = 2'd1
  } state_t;

  logic [2:0]       btn_raw;
  logic [2:0]       sync1_q;
  logic [2:0]       sync2_q;
  logic [2:0]       deb_q, deb_d;
  logic [DEB_W-1:0] cnt_q [3];
  logic [DEB_W-1:0] cnt_d [3];
  logic             deb2_prev_q;
  logic             press2;
`ifdef GATE_SEQ_FREEZE_EN
  logic             deb0_prev_q;
  logic             press0;
`endif

  state_t           state_q, state_d;
  logic [1:0]       ops_q, ops_d;       // {a, b}, b is the LSB
  logic [TICK_W-1:0] tick_q, tick_d;
  logic             tick_wrap;
  logic [6:0]       leds_q;
  logic             led7_q;
  logic             op_a, op_b;

  assign btn_raw = {io.btn2, io.btn1, io.btn0};

  // Counter counts cycles where the synchronized level disagrees with the
  // accepted level; any agreeing cycle restarts it.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_MAX) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  // Previous-level flops reset to 0 alongside deb_q, so reset release
  // alone can never look like a rising edge.
  assign press2 = deb_q[2] & ~deb2_prev_q;
`ifdef GATE_SEQ_FREEZE_EN
  assign press0 = deb_q[0] & ~deb0_prev_q;
`endif

  assign tick_wrap = (tick_q == TICK_MAX);

  always_comb begin
    state_d = state_q;
    ops_d   = ops_q;
    tick_d  = tick_q;
    case (state_q)
      ST_MANUAL: begin
        if (press2) begin
          state_d = ST_AUTO;
          ops_d   = 2'b00;
          tick_d  = '0;
        end else begin
          ops_d = {deb_q[0], deb_q[1]};
        end
      end
      ST_AUTO: begin
        // A mode press wins over a coincident wrap: operands do not step.
        if (press2) begin
          state_d = ST_MANUAL;
          tick_d  = '0;
        end
`ifdef GATE_SEQ_FREEZE_EN
        else if (press0) begin
          state_d = ST_PAUSED;
        end
`endif
        else if (tick_wrap) begin
          tick_d = '0;
          ops_d  = ops_q + 2'd1;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
`ifdef GATE_SEQ_FREEZE_EN
      ST_PAUSED: begin
        // Tick count is held so resuming finishes the interrupted step.
        if (press2) begin
          state_d = ST_MANUAL;
          tick_d  = '0;
        end else if (press0) begin
          state_d = ST_AUTO;
        end
      end
`endif
      default: begin
        state_d = ST_MANUAL;
        tick_d  = '0;
      end
    endcase
  end

  assign op_a = ops_q[1];
  assign op_b = ops_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      deb2_prev_q <= 1'b0;
`ifdef GATE_SEQ_FREEZE_EN
      deb0_prev_q <= 1'b0;
`endif
      state_q     <= ST_MANUAL;
      ops_q       <= 2'b00;
      tick_q      <= '0;
      leds_q      <= '0;
      led7_q      <= 1'b0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      deb2_prev_q <= deb_q[2];
`ifdef GATE_SEQ_FREEZE_EN
      deb0_prev_q <= deb_q[0];
`endif
      state_q     <= state_d;
      ops_q       <= ops_d;
      tick_q      <= tick_d;
      leds_q      <= {~(op_a ^ op_b), op_a ^ op_b, ~(op_a | op_b),
                      ~(op_a & op_b), op_a | op_b, op_a & op_b, ~op_a};
      // Driven from the next state so the indicator tracks state_q exactly.
      led7_q      <= (state_d != ST_MANUAL);
    end
  end

  assign io.led0 = leds_q[0];
  assign io.led1 = leds_q[1];
  assign io.led2 = leds_q[2];
  assign io.led3 = leds_q[3];
  assign io.led4 = leds_q[4];
  assign io.led5 = leds_q[5];
  assign io.led6 = leds_q[6];
  assign io.led7 = led7_q;

endmodule
